// File: rtl/fmap_pkg.sv
// Shared types and defaults for the feature-map snake streamer and its output FIFO.
package fmap_pkg;

  localparam int DEF_ROW        = 128;
  localparam int DEF_COL        = 128;
  localparam int DEF_CHANNEL_IN = 4;
  localparam int DEF_PEA_NUM    = 33;
  localparam int DEF_AW         = 14;

  localparam int PIX_W = DEF_CHANNEL_IN * 8;
  localparam int OUT_W = DEF_PEA_NUM * 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HEAD  = 3'd1,
    BODY  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

  // Counter width for a 0..n-1 range; never collapses to zero bits.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry valid/ready FIFO; the writer is credit-controlled through the count output.
module stream_fifo2
  import fmap_pkg::*;
#(
  parameter int WIDTH = PIX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem_reg [2];
  logic             wr_ptr_reg;
  logic             rd_ptr_reg;
  logic [1:0]       count_reg;
  logic             push;
  logic             pop;

  assign pop  = out_valid && out_ready;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign push = in_valid && ((count_reg != 2'd2) || pop);

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        mem_reg[gi] <= '0;
      end else if (push && (wr_ptr_reg == 1'(gi))) begin
        mem_reg[gi] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  assign out_valid = (count_reg != 2'd0);
  assign out_data  = mem_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/fmap_snake_streamer.sv
// Streams a row-major feature map out of a 1-cycle SRAM in PE-array scan order:
// two-row column-interleaved head, then serpentine body rows.
module fmap_snake_streamer
  import fmap_pkg::*;
#(
  parameter int ROW        = DEF_ROW,
  parameter int COL        = DEF_COL,
  parameter int CHANNEL_IN = DEF_CHANNEL_IN,
  parameter int PEA_NUM    = DEF_PEA_NUM,
  parameter int AW         = DEF_AW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    mem_rd_en,
  output logic [AW-1:0]           mem_addr,
  input  logic [CHANNEL_IN*8-1:0] mem_rdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PEA_NUM*8-1:0]    data_out,
  output logic                    busy,
  output logic                    done
);

  localparam int PW = CHANNEL_IN * 8;
  localparam int OW = PEA_NUM * 8;
  localparam int RW = cnt_width(ROW);
  localparam int CW = cnt_width(COL);

  localparam logic [AW-1:0] COL_STEP        = AW'(COL);
  localparam logic [AW-1:0] FIRST_BODY_BASE = AW'(2 * COL);
  localparam logic [RW-1:0] FIRST_BODY_ROW  = RW'(2);
  localparam logic [RW-1:0] LAST_ROW        = RW'(ROW - 1);
  localparam logic [CW-1:0] LAST_COL        = CW'(COL - 1);

  state_e          state_reg;
  logic [RW-1:0]   row_reg;
  logic [CW-1:0]   col_reg;
  logic [AW-1:0]   base_reg;
  logic            head_hi_reg;
  logic            inflight_reg;
  logic            busy_reg;
  logic            done_reg;

  logic [1:0]      fifo_count;
  logic [PW-1:0]   fifo_data;
  logic            fifo_pop;
  logic [1:0]      slots_used;
  logic            can_issue;
  logic            scanning;
  logic            last_head;
  logic            row_end;

  // Occupancy seen by the next read: a beat leaving this cycle frees its slot,
  // which keeps one read per cycle flowing while out_ready stays high.
  assign fifo_pop   = out_valid && out_ready;
  assign slots_used = fifo_count + {1'b0, inflight_reg} - {1'b0, fifo_pop};
  assign can_issue  = (slots_used < 2'd2);
  assign scanning   = (state_reg == HEAD) || (state_reg == BODY);

  assign mem_rd_en = scanning && can_issue;
  assign mem_addr  = base_reg + AW'(col_reg);

  assign last_head = head_hi_reg && (col_reg == LAST_COL);
  // Even body rows run right-to-left, odd rows left-to-right.
  assign row_end   = row_reg[0] ? (col_reg == LAST_COL) : (col_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      row_reg      <= '0;
      col_reg      <= '0;
      base_reg     <= '0;
      head_hi_reg  <= 1'b0;
      inflight_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      inflight_reg <= mem_rd_en;
      done_reg     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg   <= HEAD;
            busy_reg    <= 1'b1;
            row_reg     <= '0;
            col_reg     <= '0;
            base_reg    <= '0;
            head_hi_reg <= 1'b0;
          end
        end
        HEAD: begin
          if (mem_rd_en) begin
            if (!head_hi_reg) begin
              head_hi_reg <= 1'b1;
              base_reg    <= COL_STEP;
            end else if (last_head) begin
              head_hi_reg <= 1'b0;
              if (ROW == 2) begin
                state_reg <= DRAIN;
              end else begin
                state_reg <= BODY;
                row_reg   <= FIRST_BODY_ROW;
                col_reg   <= LAST_COL;
                base_reg  <= FIRST_BODY_BASE;
              end
            end else begin
              head_hi_reg <= 1'b0;
              base_reg    <= '0;
              col_reg     <= col_reg + CW'(1);
            end
          end
        end
        BODY: begin
          if (mem_rd_en) begin
            if (row_end) begin
              if (row_reg == LAST_ROW) begin
                state_reg <= DRAIN;
              end else begin
                row_reg  <= row_reg + RW'(1);
                base_reg <= base_reg + COL_STEP;
                col_reg  <= row_reg[0] ? LAST_COL : '0;
              end
            end else begin
              col_reg <= row_reg[0] ? (col_reg + CW'(1)) : (col_reg - CW'(1));
            end
          end
        end
        DRAIN: begin
          if ((fifo_count == 2'd0) && !inflight_reg) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  stream_fifo2 #(
    .WIDTH(PW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (inflight_reg),
    .in_data  (mem_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (fifo_data),
    .count    (fifo_count)
  );

  assign data_out = OW'(fifo_data);
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_fmap_snake_streamer.sv
// Bench for fmap_snake_streamer: three configurations (4x3, 2x4, 128x128) checked every cycle
// against a scan-order model, plus literal address sequences and timing points.
module tb_fmap_snake_streamer;
  import fmap_pkg::*;

  localparam int N   = 3;
  localparam int AWB = 14;
  localparam int ROWS [N] = '{4, 2, 128};
  localparam int COLS [N] = '{3, 4, 128};
  localparam int SEQ_A [12] = '{0, 3, 1, 4, 2, 5, 8, 7, 6, 9, 10, 11};
  localparam int SEQ_B [8]  = '{0, 4, 1, 5, 2, 6, 3, 7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start_r [N];
  logic ready_r [N];
  logic rd_en_w [N];
  logic ov_w    [N];
  logic busy_w  [N];
  logic done_w  [N];
  logic [AWB-1:0]   addr_w [N];
  logic [OUT_W-1:0] dout_w [N];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int beat [N], rdn [N], done_cnt [N], first_acc [N], last_acc [N], fv [N], st_tick [N], mode [N];
  bit st_req [N], prev_stall [N], prev_done [N];
  logic [OUT_W-1:0] prev_data [N];
  logic [PIX_W-1:0] acc_log [N][16];

  function automatic int total(input int i);
    return ROWS[i] * COLS[i];
  endfunction

  // k-th address of the frame, straight from the scan-order definition.
  function automatic int exp_addr(input int i, input int k);
    int r, c, j;
    if (k < 2 * COLS[i]) begin
      r = k % 2;
      c = k / 2;
    end else begin
      j = k - 2 * COLS[i];
      r = 2 + j / COLS[i];
      c = (r % 2 == 0) ? (COLS[i] - 1 - (j % COLS[i])) : (j % COLS[i]);
    end
    return r * COLS[i] + c;
  endfunction

  function automatic logic [PIX_W-1:0] pix_of(input int i, input int a);
    logic [PIX_W-1:0] v;
    v = PIX_W'(a);
    if (i == 2) v = (v << 16) ^ v ^ 32'hA500_0000;
    return v;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    logic [PIX_W-1:0] rdata = '0;
    always @(posedge clk) if (rd_en_w[gi]) rdata <= pix_of(gi, int'(addr_w[gi]));

    fmap_snake_streamer #(
      .ROW(ROWS[gi]), .COL(COLS[gi]), .CHANNEL_IN(4), .PEA_NUM(33), .AW(AWB)
    ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start_r[gi]),
      .mem_rd_en(rd_en_w[gi]),
      .mem_addr (addr_w[gi]),
      .mem_rdata(rdata),
      .out_valid(ov_w[gi]),
      .out_ready(ready_r[gi]),
      .data_out (dout_w[gi]),
      .busy     (busy_w[gi]),
      .done     (done_w[gi])
    );
  end

  task automatic chk(input string nm, input int i, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, i, cyc, got, exp);
    end
  endtask

  task automatic check_cycle();
    bit pop;
    if (!rst_n) return;
    for (int i = 0; i < N; i++) begin
      pop = ov_w[i] && ready_r[i];
      if (prev_stall[i]) begin
        chk("stall_valid", i, ov_w[i], 1'b1);
        chk("stall_data", i, dout_w[i], prev_data[i]);
      end
      if (ov_w[i]) begin
        if (beat[i] < total(i)) chk("data", i, dout_w[i], OUT_W'(pix_of(i, exp_addr(i, beat[i]))));
        else chk("extra_beat", i, beat[i], total(i) - 1);
        chk("busy_valid", i, busy_w[i], 1'b1);
      end
      if (rd_en_w[i]) begin
        if (rdn[i] < total(i)) chk("rd_addr", i, addr_w[i], exp_addr(i, rdn[i]));
        else chk("extra_read", i, rdn[i], total(i) - 1);
        chk("credit", i, (rdn[i] - beat[i] + 1 - int'(pop)) <= 2, 1'b1);
        chk("busy_read", i, busy_w[i], 1'b1);
        rdn[i]++;
      end
      if (prev_done[i]) chk("busy_after_done", i, busy_w[i], 1'b0);
      if (pop) begin
        if (beat[i] < 16) acc_log[i][beat[i]] = dout_w[i][PIX_W-1:0];
        if (beat[i] == 0) first_acc[i] = cyc;
        last_acc[i] = cyc;
        beat[i]++;
      end
      if (fv[i] < 0 && ov_w[i]) fv[i] = cyc;
      if (done_w[i]) begin
        chk("done_beats", i, beat[i], total(i));
        chk("done_latency", i, cyc - last_acc[i], 2);
        done_cnt[i]++;
        beat[i] = 0;
        rdn[i] = 0;
      end
      prev_stall[i] = ov_w[i] && !ready_r[i];
      prev_data[i]  = dout_w[i];
      prev_done[i]  = done_w[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      start_r[i] = st_req[i];
      st_req[i]  = 1'b0;
      case (mode[i])
        0:       ready_r[i] = 1'b1;
        1:       ready_r[i] = (cyc % 2 == 0);
        default: ready_r[i] = 1'($urandom_range(0, 1));
      endcase
    end
    #1;
    check_cycle();
    cyc++;
  endtask

  task automatic start_frame(input int i);
    st_req[i]  = 1'b1;
    st_tick[i] = cyc;
    fv[i]      = -1;
    for (int k = 0; k < 16; k++) acc_log[i][k] = '1;
  endtask

  task automatic run_until(input int i, input int target, input int budget);
    int n;
    n = 0;
    while (done_cnt[i] < target && n < budget) begin
      tick();
      n++;
    end
    chk("frame_timeout", i, done_cnt[i], target);
  endtask

  task automatic check_zero(input int i);
    chk("zero_rd_en", i, rd_en_w[i], 1'b0);
    chk("zero_addr", i, addr_w[i], '0);
    chk("zero_valid", i, ov_w[i], 1'b0);
    chk("zero_data", i, dout_w[i], '0);
    chk("zero_busy", i, busy_w[i], 1'b0);
    chk("zero_done", i, done_w[i], 1'b0);
  endtask

  task automatic check_order(input int i);
    if (i == 0) for (int k = 0; k < 12; k++) chk("order_4x3", i, acc_log[i][k], SEQ_A[k]);
    else        for (int k = 0; k < 8;  k++) chk("order_2x4", i, acc_log[i][k], SEQ_B[k]);
  endtask

  task automatic reset_model();
    for (int i = 0; i < N; i++) begin
      beat[i] = 0;
      rdn[i] = 0;
      prev_stall[i] = 1'b0;
      prev_done[i] = 1'b0;
    end
  endtask

  initial begin
    int c0, n, d0, d1;
    for (int i = 0; i < N; i++) begin
      start_r[i] = 1'b0; ready_r[i] = 1'b1; st_req[i] = 1'b0; mode[i] = 0;
      done_cnt[i] = 0; fv[i] = -1; first_acc[i] = 0; last_acc[i] = 0; st_tick[i] = 0;
      prev_data[i] = '0;
    end
    reset_model();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) check_zero(i);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();

    // Frame 1, all configs, out_ready high; stray starts on inst0 mid-frame and in DONE.
    c0 = cyc;
    for (int i = 0; i < N; i++) start_frame(i);
    while (cyc < c0 + 6) tick();
    st_req[0] = 1'b1;
    while (cyc < c0 + 16) tick();
    st_req[0] = 1'b1;
    tick();
    chk("done_cycle", 0, done_w[0], 1'b1);
    repeat (4) tick();
    chk("start_in_done_ignored_busy", 0, busy_w[0], 1'b0);
    chk("start_in_done_ignored_valid", 0, ov_w[0], 1'b0);
    run_until(2, 1, 17000);
    for (int i = 0; i < N; i++) begin
      chk("single_done", i, done_cnt[i], 1);
      chk("first_valid_lat", i, fv[i] - st_tick[i], 3);
      chk("throughput", i, last_acc[i] - first_acc[i], total(i) - 1);
    end
    check_order(0);
    check_order(1);

    // Backpressure: toggled and random out_ready.
    mode[0] = 1; mode[1] = 2;
    start_frame(0); start_frame(1);
    run_until(0, 2, 300);
    run_until(1, 2, 300);
    check_order(0);
    check_order(1);
    mode[0] = 2;
    start_frame(0);
    run_until(0, 3, 300);
    check_order(0);

    // Asynchronous abort at beat 5, then a clean restart.
    mode[0] = 0; mode[1] = 0;
    start_frame(0); start_frame(1);
    n = 0;
    while (beat[0] != 5 && n < 50) begin
      tick();
      n++;
    end
    chk("reach_beat5", 0, beat[0], 5);
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) check_zero(i);
    reset_model();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("no_done_after_abort", 0, done_cnt[0], d0);
    chk("no_done_after_abort", 1, done_cnt[1], d1);
    chk("idle_after_abort", 0, busy_w[0], 1'b0);
    start_frame(0); start_frame(1);
    run_until(0, d0 + 1, 100);
    run_until(1, d1 + 1, 100);
    chk("restart_first_valid_lat", 0, fv[0] - st_tick[0], 3);
    check_order(0);
    check_order(1);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
